ram1p_arb: RTL and testbench

Sequencer and two-requester arbiter for one single-port, read-first cache SRAM subarray (DEPTH x WIDTH, 1 cycle read latency, registered read address). Requester A is the cache pipeline and requester B is the refill/flush path. The block grants at most one access per cycle and returns read data to the requester that issued the read. It also runs a zero-fill sweep of every address after reset and on request, so tag and valid arrays start clean.

---
 rtl/ram1p_arb.sv | 121 ++++++++++++
 tb/tb_ram1p_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram1p_arb.sv
// Single-port read-first SRAM sequencer: zero-fill sweep after reset/clear, then
// round-robin arbitration between cache pipeline (A) and refill path (B).
module ram1p_arb #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 44,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    output logic             busy,

    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,

    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,

    output logic             ram_ce,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    localparam logic [0:0] StSweep = 1'b0;
    localparam logic [0:0] StServe = 1'b1;
    localparam logic [AW-1:0] CntMax = AW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          lastgnt_q, lastgnt_d;  // 0: A granted last, 1: B granted last
    logic          rpend_a_q, rpend_a_d;
    logic          rpend_b_q, rpend_b_d;
    logic          serve;

    assign serve = (state_q == StServe);
    assign busy  = (state_q == StSweep);

    // Under contention the requester that was not granted last wins.
    assign a_gnt = serve & a_req & (~b_req | lastgnt_q);
    assign b_gnt = serve & b_req & (~a_req | ~lastgnt_q);

    assign a_rvalid = rpend_a_q;
    assign b_rvalid = rpend_b_q;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (!serve) begin
            ram_ce   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = cnt_q;
        end else if (a_gnt) begin
            ram_ce   = 1'b1;
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_wdata;
        end else if (b_gnt) begin
            ram_ce   = 1'b1;
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lastgnt_d = lastgnt_q;
        rpend_a_d = a_gnt & ~a_we;
        rpend_b_d = b_gnt & ~b_we;
        if (!serve) begin
            if (cnt_q == CntMax) begin
                state_d = StServe;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (a_gnt) lastgnt_d = 1'b0;
            if (b_gnt) lastgnt_d = 1'b1;
            // A grant in the clear cycle still completes; its read returns in SWEEP.
            if (clear) begin
                state_d = StSweep;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StSweep;
            cnt_q     <= '0;
            lastgnt_q <= 1'b1;
            rpend_a_q <= 1'b0;
            rpend_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lastgnt_q <= lastgnt_d;
            rpend_a_q <= rpend_a_d;
            rpend_b_q <= rpend_b_d;
        end
    end

endmodule

// File: tb/tb_ram1p_arb.sv
// Directed testbench for ram1p_arb with a behavioural read-first single-port RAM.
module tb_ram1p_arb;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WIDTH = 44;
    localparam int unsigned AW = 6;

    logic             clk, resetn, clear, busy;
    logic             a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_wdata, a_rdata;
    logic             b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_wdata, b_rdata;
    logic             ram_ce, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din, ram_dout;

    int n_checks = 0;
    int n_fail = 0;

    ram1p_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .busy(busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first RAM, pre-filled with non-zero junk so the sweep is visible.
    logic [WIDTH-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 44'hBAD_0000_0000 | WIDTH'(i + 1);
        ram_dout = '0;
        forever begin
            @(posedge clk);
            if (ram_ce) begin
                ram_dout <= mem[ram_addr];
                if (ram_we) mem[ram_addr] <= ram_din;
            end
        end
    end

    task automatic test_reset();
        resetn = 1'b0; clear = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if ({busy, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ce, ram_we} !== 7'b1000011 ||
                ram_addr !== '0 || ram_din !== '0) begin
                n_fail++;
                $display("FAIL reset_state: busy,gnt,rvalid,ce,we=%b addr=%0d din=%h required 1000011 0 0",
                         {busy, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ce, ram_we}, ram_addr, ram_din);
            end
        end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 ||
                ram_addr !== AW'(i) || ram_din !== '0) begin
                n_fail++;
                $display("FAIL reset_sweep[%0d]: busy=%b ce=%b we=%b addr=%0d din=%h required 1 1 1 %0d 0",
                         i, busy, ram_ce, ram_we, ram_addr, ram_din, i);
            end
        end
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 6'd33; #1;
        n_checks++;
        if (busy !== 1'b0 || a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_fall: busy=%b a_gnt=%b required 0 1", busy, a_gnt);
        end
        @(negedge clk); a_req = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_read_zero: a_rvalid=%b a_rdata=%h required 1 0", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_single();
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 44'h123; #1;
        n_checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_ce !== 1'b1 || ram_we !== 1'b1 ||
            ram_addr !== 6'd5 || ram_din !== 44'h123) begin
            n_fail++;
            $display("FAIL single_write: gnt=%b%b ce=%b we=%b addr=%0d din=%h required 10 1 1 5 123",
                     a_gnt, b_gnt, ram_ce, ram_we, ram_addr, ram_din);
        end
        @(negedge clk); a_we = 1'b0; #1;
        n_checks++;
        if (a_gnt !== 1'b1 || a_rvalid !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 6'd5) begin
            n_fail++;
            $display("FAIL single_read_gnt: a_gnt=%b a_rvalid=%b we=%b addr=%0d required 1 0 0 5",
                     a_gnt, a_rvalid, ram_we, ram_addr);
        end
        @(negedge clk); a_req = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 44'h123 || b_rvalid !== 1'b0 || ram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_data: a_rvalid=%b a_rdata=%h b_rvalid=%b ce=%b required 1 123 0 0",
                     a_rvalid, a_rdata, b_rvalid, ram_ce);
        end
        @(negedge clk); #1;
        n_checks++;
        if (a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rvalid_once: a_rvalid=%b required 0", a_rvalid);
        end
    endtask

    task automatic test_hazard();
        @(negedge clk); b_req = 1'b1; b_we = 1'b1; b_addr = 6'd63; b_wdata = 44'hABC; #1;
        n_checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_write_gnt: a_gnt=%b b_gnt=%b required 0 1", a_gnt, b_gnt);
        end
        @(negedge clk); b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 6'd63; #1;
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_read_gnt: a_gnt=%b required 1", a_gnt);
        end
        @(negedge clk); a_req = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 44'hABC || b_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_read_data: a_rvalid=%b a_rdata=%h b_rvalid=%b required 1 abc 0",
                     a_rvalid, a_rdata, b_rvalid);
        end
    endtask

    task automatic test_contention();
        logic exp_a, exp_arv, exp_brv;
        // B write leaves lastgnt at B, so contention must open with A.
        @(negedge clk); b_req = 1'b1; b_we = 1'b1; b_addr = 6'd62; b_wdata = 44'h77; #1;
        n_checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_prime: a_gnt=%b b_gnt=%b required 0 1", a_gnt, b_gnt);
        end
        @(negedge clk); b_we = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_a   = (k % 2 == 0);
            exp_arv = (k > 0) && ((k - 1) % 2 == 0);
            exp_brv = (k > 0) && ((k - 1) % 2 == 1);
            n_checks++;
            if (a_gnt !== exp_a || b_gnt !== !exp_a || a_rvalid !== exp_arv ||
                b_rvalid !== exp_brv || (exp_arv && a_rdata !== 44'h123) ||
                (exp_brv && b_rdata !== 44'h77)) begin
                n_fail++;
                $display("FAIL contention[%0d]: gnt=%b%b rvalid=%b%b rdata=%h required gnt=%b%b rvalid=%b%b",
                         k, a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, exp_a, !exp_a, exp_arv, exp_brv);
            end
        end
        @(negedge clk); a_req = 1'b0; b_req = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b1 || b_rdata !== 44'h77 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_tail: gnt=%b%b rvalid=%b%b b_rdata=%h required 00 01 77",
                     a_gnt, b_gnt, a_rvalid, b_rvalid, b_rdata);
        end
    endtask

    task automatic test_clear();
        @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 6'd7; a_wdata = 44'h55; #1;
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_setup_write: a_gnt=%b required 1", a_gnt);
        end
        @(negedge clk); a_we = 1'b0; clear = 1'b1; #1;
        n_checks++;
        if (a_gnt !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_read_gnt: a_gnt=%b busy=%b required 1 0", a_gnt, busy);
        end
        @(negedge clk); a_req = 1'b0; clear = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 44'h55 || busy !== 1'b1 || ram_addr !== '0 || a_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_inflight_read: a_rvalid=%b a_rdata=%h busy=%b addr=%0d a_gnt=%b required 1 55 1 0 0",
                     a_rvalid, a_rdata, busy, ram_addr, a_gnt);
        end
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            clear = (i == 10);
            if (i == 60) begin a_req = 1'b1; a_we = 1'b0; a_addr = 6'd7; end
            #1;
            n_checks++;
            if (busy !== 1'b1 || ram_addr !== AW'(i) || ram_we !== 1'b1 || a_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_sweep[%0d]: busy=%b addr=%0d we=%b a_gnt=%b required 1 %0d 1 0",
                         i, busy, ram_addr, ram_we, a_gnt, i);
            end
        end
        @(negedge clk); clear = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0 || a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_busy_fall: busy=%b a_gnt=%b required 0 1", busy, a_gnt);
        end
        @(negedge clk); a_addr = 6'd5; #1;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== '0 || a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_read7_zero: a_rvalid=%b a_rdata=%h a_gnt=%b required 1 0 1",
                     a_rvalid, a_rdata, a_gnt);
        end
        @(negedge clk); a_req = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== '0) begin
            n_fail++;
            $display("FAIL clear_read5_zero: a_rvalid=%b a_rdata=%h required 1 0", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 6'd62; #1;
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_read_gnt: a_gnt=%b required 1", a_gnt);
        end
        @(negedge clk); a_req = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_rvalid_before: a_rvalid=%b required 1", a_rvalid);
        end
        resetn = 1'b0; #1;
        n_checks++;
        if (a_rvalid !== 1'b0 || busy !== 1'b1 || ram_addr !== '0 || ram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_rvalid_drop: a_rvalid=%b busy=%b addr=%0d we=%b required 0 1 0 1",
                     a_rvalid, busy, ram_addr, ram_we);
        end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b1 || ram_addr !== AW'(i)) begin
                n_fail++;
                $display("FAIL rstmid_partial[%0d]: busy=%b addr=%0d required 1 %0d", i, busy, ram_addr, i);
            end
        end
        resetn = 1'b0; a_req = 1'b1; a_we = 1'b1; b_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({busy, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ce, ram_we} !== 7'b1000011 ||
                ram_addr !== '0 || ram_din !== '0) begin
                n_fail++;
                $display("FAIL rstmid_hold[%0d]: busy,gnt,rvalid,ce,we=%b addr=%0d din=%h required 1000011 0 0",
                         j, {busy, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ce, ram_we}, ram_addr, ram_din);
            end
        end
        @(negedge clk); resetn = 1'b1; a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b1 || ram_addr !== AW'(i) || ram_din !== '0) begin
                n_fail++;
                $display("FAIL rstmid_sweep[%0d]: busy=%b addr=%0d din=%h required 1 %0d 0",
                         i, busy, ram_addr, ram_din, i);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_busy_fall: busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hazard();
        test_contention();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
